// File: rtl/hf_seg7_bank_if.sv
// Bus bundle between user logic (master) and the hf_seg7_bank display driver (slave).
// With HF_SEG7_BLINK_EN defined the bundle also carries the per-digit blink mask.
interface hf_seg7_bank_if #(
    parameter int NDIGITS = 6,
    parameter int WIDTH   = 20
);
    logic                   load;
    logic [WIDTH-1:0]       value;
    logic                   mode;
    logic                   blank_lz;
    logic [NDIGITS-1:0]     dp;
`ifdef HF_SEG7_BLINK_EN
    logic [NDIGITS-1:0]     blink;
`endif
    logic                   busy;
    logic                   done;
    logic                   overflow;
    logic [8*NDIGITS-1:0]   seg;

    modport master (
        output load, value, mode, blank_lz, dp,
`ifdef HF_SEG7_BLINK_EN
        output blink,
`endif
        input  busy, done, overflow, seg
    );

    modport slave (
        input  load, value, mode, blank_lz, dp,
`ifdef HF_SEG7_BLINK_EN
        input  blink,
`endif
        output busy, done, overflow, seg
    );
endinterface

// File: rtl/hf_seg7_bank.sv
// N-digit seven-segment driver: captures a binary value and shows it in hex or in decimal
// (iterative double-dabble). Optional digit blinking is enabled by defining HF_SEG7_BLINK_EN.
module hf_seg7_bank #(
    parameter int NDIGITS   = 6,
    parameter int WIDTH     = 20,
    parameter int BLINK_DIV = 25000000
) (
    input  logic           max10_clk1_50,
    input  logic           reset,
    hf_seg7_bank_if.slave  bus
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] CONVERT = 2'd1;
    localparam logic [1:0] UPDATE  = 2'd2;

    localparam int BCD_W = 4 * NDIGITS;
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    function automatic logic [63:0] dec_limit(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) r = r * 64'd10;
        return r - 64'd1;
    endfunction

    localparam logic [63:0] DEC_MAX = dec_limit(NDIGITS);

    if (NDIGITS < 1 || NDIGITS > 8 || WIDTH < 1 || WIDTH > 32 || BLINK_DIV < 1) begin : g_bad_param
        $error("hf_seg7_bank: parameter out of range");
    end

    // Segment pattern gfedcba, active low, for one hex digit.
    function automatic logic [6:0] enc7(input logic [3:0] d);
        case (d)
            4'h0: enc7 = 7'h40;
            4'h1: enc7 = 7'h79;
            4'h2: enc7 = 7'h24;
            4'h3: enc7 = 7'h30;
            4'h4: enc7 = 7'h19;
            4'h5: enc7 = 7'h12;
            4'h6: enc7 = 7'h02;
            4'h7: enc7 = 7'h78;
            4'h8: enc7 = 7'h00;
            4'h9: enc7 = 7'h10;
            4'hA: enc7 = 7'h08;
            4'hB: enc7 = 7'h03;
            4'hC: enc7 = 7'h46;
            4'hD: enc7 = 7'h21;
            4'hE: enc7 = 7'h06;
            default: enc7 = 7'h0E;
        endcase
    endfunction

    logic [1:0]             state_reg;
    logic                   start_reg;
    logic                   busy_reg;
    logic                   done_reg;
    logic                   overflow_reg;
    logic [8*NDIGITS-1:0]   seg_reg;
    logic [WIDTH-1:0]       value_cap_reg;
    logic                   mode_cap_reg;
    logic                   blz_cap_reg;
    logic [NDIGITS-1:0]     dp_cap_reg;
    logic [BCD_W-1:0]       bcd_reg;
    logic [WIDTH-1:0]       bin_reg;
    logic [CNT_W-1:0]       cnt_reg;

    logic [BCD_W-1:0]       bcd_adj;
    logic [BCD_W+WIDTH-1:0] dd_shift;
    logic [BCD_W-1:0]       hex_ext;
    logic [63:0]            value_ext;
    logic                   ovf_calc;
    logic [NDIGITS:1]       upper_zero;
    logic [8*NDIGITS-1:0]   image;

    // Add-3 correction on every BCD digit before each shift.
    genvar gi;
    for (gi = 0; gi < NDIGITS; gi++) begin : g_dabble
        logic [3:0] d;
        assign d = bcd_reg[4*gi +: 4];
        assign bcd_adj[4*gi +: 4] = (d >= 4'd5) ? 4'(d + 4'd3) : d;
    end
    assign dd_shift = {bcd_adj, bin_reg} << 1;

    if (WIDTH >= BCD_W) begin : g_hex_trunc
        assign hex_ext = value_cap_reg[BCD_W-1:0];
    end else begin : g_hex_pad
        assign hex_ext = {{(BCD_W-WIDTH){1'b0}}, value_cap_reg};
    end

    assign value_ext = {{(64-WIDTH){1'b0}}, value_cap_reg};
    assign ovf_calc  = mode_cap_reg ? (value_ext > DEC_MAX)
                                    : ((value_ext >> BCD_W) != 64'd0);

    // A digit blanks when it and every digit above it are zero; digit 0 never blanks.
    assign upper_zero[NDIGITS] = 1'b1;
    for (gi = 0; gi < NDIGITS; gi++) begin : g_digit
        logic [3:0] nib;
        logic       blank;
        assign nib = mode_cap_reg ? bcd_reg[4*gi +: 4] : hex_ext[4*gi +: 4];
        if (gi == 0) begin : g_lsd
            assign blank = 1'b0;
        end else begin : g_upper
            assign upper_zero[gi] = (nib == 4'd0) && upper_zero[gi+1];
            assign blank = blz_cap_reg && upper_zero[gi];
        end
        assign image[8*gi +: 8] = ovf_calc ? 8'hBF
                                : {~dp_cap_reg[gi], blank ? 7'h7F : enc7(nib)};
    end

    // The cycle after capture (start_reg) seeds the converter, so both paths
    // spend one extra clock in IDLE before CONVERT or UPDATE.
    always_ff @(posedge max10_clk1_50) begin
        if (reset) begin
            state_reg     <= IDLE;
            start_reg     <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            overflow_reg  <= 1'b0;
            seg_reg       <= '1;
            value_cap_reg <= '0;
            mode_cap_reg  <= 1'b0;
            blz_cap_reg   <= 1'b0;
            dp_cap_reg    <= '0;
            bcd_reg       <= '0;
            bin_reg       <= '0;
            cnt_reg       <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start_reg) begin
                        start_reg <= 1'b0;
                        if (mode_cap_reg) begin
                            state_reg <= CONVERT;
                            bcd_reg   <= '0;
                            bin_reg   <= value_cap_reg;
                            cnt_reg   <= '0;
                        end else begin
                            state_reg <= UPDATE;
                        end
                    end else if (bus.load) begin
                        value_cap_reg <= bus.value;
                        mode_cap_reg  <= bus.mode;
                        blz_cap_reg   <= bus.blank_lz;
                        dp_cap_reg    <= bus.dp;
                        busy_reg      <= 1'b1;
                        start_reg     <= 1'b1;
                    end
                end
                CONVERT: begin
                    bcd_reg <= dd_shift[BCD_W+WIDTH-1:WIDTH];
                    bin_reg <= dd_shift[WIDTH-1:0];
                    cnt_reg <= cnt_reg + CNT_W'(1);
                    if (cnt_reg == CNT_W'(WIDTH - 1)) state_reg <= UPDATE;
                end
                UPDATE: begin
                    seg_reg      <= image;
                    overflow_reg <= ovf_calc;
                    done_reg     <= 1'b1;
                    busy_reg     <= 1'b0;
                    state_reg    <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_reg;
    assign bus.done     = done_reg;
    assign bus.overflow = overflow_reg;

`ifdef HF_SEG7_BLINK_EN
    localparam int DIV_W = $clog2(BLINK_DIV + 1);

    logic [DIV_W-1:0]     div_cnt_reg;
    logic                 phase_reg;
    logic [8*NDIGITS-1:0] seg_out;

    always_ff @(posedge max10_clk1_50) begin
        if (reset) begin
            div_cnt_reg <= '0;
            phase_reg   <= 1'b0;
        end else if (div_cnt_reg == DIV_W'(BLINK_DIV - 1)) begin
            div_cnt_reg <= '0;
            phase_reg   <= ~phase_reg;
        end else begin
            div_cnt_reg <= div_cnt_reg + DIV_W'(1);
        end
    end

    // The blink mask is applied live so user logic can toggle it without a reload.
    always_comb begin
        seg_out = seg_reg;
        for (int i = 0; i < NDIGITS; i++) begin
            if (phase_reg && bus.blink[i]) seg_out[8*i +: 8] = 8'hFF;
        end
    end
    assign bus.seg = seg_out;
`else
    assign bus.seg = seg_reg;
`endif
endmodule
